// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: debounced two-button lighting FSM driving glitch-free RGB PWM into SB_RGBA_DRV
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   button_1_n_i, button_2_n_i   raw buttons from SB_IO, low = pressed
//   blue_pwm_o, green_pwm_o,     registered PWM to the driver's colour-mapped pins
//   red_pwm_o
//   mode_o                       0 OFF, 1 SOLID, 2 BREATHE, 3 CYCLE
//   colour_o                     colour index 0..6
module rgb_pwm_ctrl #(
    parameter int PWM_BITS      = 8,
    parameter int DEBOUNCE_LOG2 = 16,
    parameter int RAMP_LOG2     = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_1_n_i,
    input  logic       button_2_n_i,
    output logic       blue_pwm_o,
    output logic       green_pwm_o,
    output logic       red_pwm_o,
    output logic [1:0] mode_o,
    output logic [2:0] colour_o
);
    typedef enum logic [1:0] {OFF, SOLID, BREATHE, CYCLE} mode_t;

    // bit n set = channel lit for colour index n
    localparam logic [7:0] R_MAP = 8'b0110_1001;
    localparam logic [7:0] G_MAP = 8'b0101_1010;
    localparam logic [7:0] B_MAP = 8'b0111_0100;

    logic [1:0]               sync1_q, sync2_q, db_q, db_d, acc, press;
    logic [DEBOUNCE_LOG2-1:0] dbc_q [2];
    logic [DEBOUNCE_LOG2-1:0] dbc_d [2];

    mode_t                    mode_q;
    logic [2:0]               colour_q, colour_inc;
    logic [PWM_BITS-1:0]      level_q, lvl_up, lvl_dn;
    logic                     dir_q, paused_q, ramp_on;
    logic [RAMP_LOG2-1:0]     rc_q;

    logic [PWM_BITS-1:0]      cnt_q, bright, duty_r_q, duty_g_q, duty_b_q;

    // Debounce: acceptance is decided combinationally so the press pulse and the
    // debounced-state update land on the same edge (2 sync + 2**DEBOUNCE_LOG2 cycles).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc[i]   = (sync2_q[i] != db_q[i]) && (dbc_q[i] == '1);
            db_d[i]  = acc[i] ? sync2_q[i] : db_q[i];
            dbc_d[i] = (sync2_q[i] == db_q[i] || acc[i]) ? '0 : dbc_q[i] + DEBOUNCE_LOG2'(1);
            press[i] = acc[i] && !sync2_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            db_q     <= '1;
            dbc_q[0] <= '0;
            dbc_q[1] <= '0;
        end else begin
            sync1_q  <= {button_2_n_i, button_1_n_i};
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            dbc_q    <= dbc_d;
        end
    end

    always_comb begin
        colour_inc = (colour_q == 3'd6) ? 3'd0 : colour_q + 3'd1;
        lvl_up     = level_q + PWM_BITS'(1);
        lvl_dn     = level_q - PWM_BITS'(1);
        ramp_on    = mode_q[1] && !paused_q;
        bright     = (mode_q == OFF) ? '0 : (mode_q == SOLID) ? '1 : level_q;
    end

    // Mode FSM; press_1 takes priority and discards a coincident press_2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= OFF;
            colour_q <= '0;
            level_q  <= '0;
            dir_q    <= 1'b1;
            paused_q <= 1'b0;
            rc_q     <= '0;
        end else if (press[0]) begin
            mode_q   <= mode_t'(mode_q + 2'd1);
            paused_q <= 1'b0;
            level_q  <= '0;
            dir_q    <= 1'b1;
            rc_q     <= '0;
        end else begin
            if (press[1] && mode_q == SOLID)
                colour_q <= colour_inc;
            if (press[1] && mode_q[1])
                paused_q <= !paused_q;
            if (ramp_on) begin
                rc_q <= rc_q + RAMP_LOG2'(1);
                // direction flips on the step that reaches an extreme, so each extreme is held one step
                if (rc_q == '1 && dir_q) begin
                    level_q <= lvl_up;
                    dir_q   <= (lvl_up != '1);
                end
                if (rc_q == '1 && !dir_q) begin
                    level_q <= lvl_dn;
                    dir_q   <= (lvl_dn == '0);
                    if (lvl_dn == '0 && mode_q == CYCLE)
                        colour_q <= colour_inc;
                end
            end
        end
    end

    // Duty shadows reload only on counter wrap so each period carries a single duty value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            duty_r_q    <= '0;
            duty_g_q    <= '0;
            duty_b_q    <= '0;
            red_pwm_o   <= 1'b0;
            green_pwm_o <= 1'b0;
            blue_pwm_o  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + PWM_BITS'(1);
            if (cnt_q == '1) begin
                duty_r_q <= R_MAP[colour_q] ? bright : '0;
                duty_g_q <= G_MAP[colour_q] ? bright : '0;
                duty_b_q <= B_MAP[colour_q] ? bright : '0;
            end
            red_pwm_o   <= cnt_q < duty_r_q;
            green_pwm_o <= cnt_q < duty_g_q;
            blue_pwm_o  <= cnt_q < duty_b_q;
        end
    end

    always_comb begin
        mode_o   = mode_q;
        colour_o = colour_q;
    end
endmodule
